arb_mux_nx1: RTL
================

Name: arb_mux_nx1

Overview:
- Parametrised, registered N:1 channel multiplexer with valid/ready handshaking on every input and on the output.
- Selection is either external (sel-driven, like the combinational selectors) or internal round-robin arbitration, chosen by a mode pin.
- Sits between multiple producers (ALU, load unit, sort/factorial engines) and a single consumer such as the register-file writeback path or the result bus.
- Adds one pipeline stage and source tagging.

Parameters:
- N, 4, number of input channels (N >= 2).
- WIDTH, 8, data width per channel.
- SELW, $clog2(N), select/source-index width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-channel valid; bit i belongs to channel i.
- in_data  input  N*WIDTH  concatenated channel data; channel i occupies in_data[i*WIDTH +: WIDTH].
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- mode  input  1  0 = external select, 1 = round-robin.
- sel  input  SELW  channel index used when mode = 0.
- out_valid  output  1  output register holds a valid word.
- out_data  output  WIDTH  registered selected data.
- out_src  output  SELW  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (asynchronous assert, synchronous release): out_valid = 0, out_data = 0, out_src = 0, rr_ptr = N-1. The first round-robin grant therefore favours channel 0.
- load_en = !out_valid || out_ready. This allows a full-throughput single stage with no bubble when the consumer is ready.
- Grant in mode 0:
  - grant = sel, grant_valid = in_valid[sel].
  - sel >= N (non-power-of-2 N) gives grant_valid = 0.
- Grant in mode 1:
  - Search channels rr_ptr+1, rr_ptr+2, ... modulo N, wrapping past N-1 to 0.
  - The first asserted in_valid wins; grant_valid = |in_valid.
- in_ready[i] = load_en && grant_valid && (grant == i). It is combinational and must not depend on in_valid of other channels in mode 0.
- Transfer on channel i = in_valid[i] && in_ready[i]. On the next clock edge:
  - out_data <= in_data[grant]
  - out_src <= grant
  - out_valid <= 1
  - rr_ptr <= grant
- rr_ptr updates on accepted transfers in both modes. It holds otherwise.
- load_en && !grant_valid: out_valid <= 0. out_data and out_src hold their last values.
- !load_en (out_valid && !out_ready): the output register holds all fields, in_ready = 0, rr_ptr holds.
- Latency: accepted input appears on out_data 1 cycle later. Throughput: 1 word/cycle while out_ready = 1.
- Simultaneous output handoff and new accept in the same cycle is legal and required (load_en is true via out_ready).
- Mode or sel changes take effect in the same cycle's grant. They never alter data already in the output register.
- Stability contract: producers hold in_data/in_valid until accepted. The block does not require it, but a producer that drops valid without ready loses nothing.
- No combinational path from in_valid/in_data to out_*. The only path from out_ready to in_ready is combinational.

Decomposition:
- No shared package needed; SELW is derived locally.
- One sub-module, rr_arbiter_n:
  - Inputs: req[N], ptr[SELW].
  - Outputs: gnt_idx[SELW], gnt_any.
  - Purely combinational rotate-priority search, reused by later multi-port blocks.
- The data path (indexed part-select on in_data), handshake and register live in arb_mux_nx1.

Test Plan:
1. Reset mid-stream: out_valid = 1 with out_data = 0xA5, assert rst_n = 0 without a clock edge -> out_valid, out_data and out_src immediately 0. After release, a mode 1 request on all channels grants channel 0 first.
2. Mode 0, N = 4, WIDTH = 8, sel = 2, in_data = {8'h44, 8'h33, 8'h22, 8'h11}, in_valid = 4'b0100, out_ready = 1 -> in_ready = 4'b0100. The next cycle gives out_data = 0x33, out_src = 2, out_valid = 1.
3. Mode 0 with sel = 1 and in_valid = 4'b0100 -> in_ready = 0. The next cycle gives out_valid = 0 and out_data holding its previous value.
4. Mode 1, in_valid = 4'b1111 for 8 cycles, out_ready = 1 -> out_src sequence 0,1,2,3,0,1,2,3, one word per cycle.
5. Mode 1, wrap-around and skipping: rr_ptr = 2 and in_valid = 4'b0011 -> grant 0. Then, with in_valid = 4'b0010 -> grant 1. Then, with in_valid = 4'b0001 -> grant 0.
6. Backpressure: out_valid = 1 (0x11, src 0), out_ready = 0 for 3 cycles with in_valid = 4'b1111 -> out_data stays 0x11, in_ready = 0, rr_ptr unchanged. Raising out_ready gives 0x22 (src 1) on the following cycle.

Source files
------------

// File: rtl/arb_mux_nx1_pkg.sv
// Shared definitions for the N:1 arbitrating multiplexer.
//   mode_e : encoding of the mode pin (external select vs. round-robin).
package arb_mux_nx1_pkg;

  typedef enum logic {
    MODE_EXT = 1'b0,  // grant follows the sel input
    MODE_RR  = 1'b1   // grant comes from the round-robin arbiter
  } mode_e;

endpackage

// File: rtl/arb_mux_nx1_rr.sv
// rr_arbiter_n: purely combinational rotate-priority search.
//   req     : per-channel request vector, bit i = channel i
//   ptr     : index of the last granted channel; search starts at ptr+1
//   gnt_idx : index of the winning channel (0 when nothing requests)
//   gnt_any : at least one channel requests
module rr_arbiter_n #(
  parameter  int N    = 4,
  localparam int SELW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_any
);

  int idx;

  // NOTE: every output gets a default before the search loop so no path
  // through the block leaves a value unassigned (which would infer a latch).
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    // Walk ptr+1, ptr+2, ... wrapping modulo N; the first request wins.
    // Offset N brings the search back to ptr itself, checked last.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/arb_mux_nx1.sv
// arb_mux_nx1: registered N:1 channel multiplexer with valid/ready on every
// input and on the output, external or round-robin selection, source tagging.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   in_valid   : per-channel valid
//   in_data    : channel i at in_data[i*WIDTH +: WIDTH]
//   in_ready   : per-channel ready, one-hot or zero
//   mode       : 0 = use sel, 1 = round-robin
//   sel        : channel index used in external mode
//   out_valid  : output register holds a valid word
//   out_data   : registered selected data
//   out_src    : channel that produced out_data
//   out_ready  : consumer takes out_data this cycle
module arb_mux_nx1
  import arb_mux_nx1_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int WIDTH = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  input  logic                 out_ready
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  rr_idx;
  logic             rr_any;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic             load_en;
  logic [WIDTH-1:0] grant_data;

  rr_arbiter_n #(.N(N)) u_rr (
    .req     (in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (rr_idx),
    .gnt_any (rr_any)
  );

  // The register may load when empty or when its word leaves this cycle,
  // giving full throughput with no bubble.
  assign load_en = !out_valid || out_ready;

  // In external mode only the selected channel's valid matters, so in_ready
  // never depends on the other channels. Out-of-range sel grants nothing.
  always_comb begin
    grant       = sel;
    grant_valid = 1'b0;
    if (mode_e'(mode) == MODE_RR) begin
      grant       = rr_idx;
      grant_valid = rr_any;
    end else if (int'(sel) < N) begin
      grant_valid = in_valid[sel];
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_ready[i] = load_en && grant_valid && (grant == SELW'(i));
    end
  end

  assign grant_data = in_data[int'(grant)*WIDTH +: WIDTH];

  // NOTE: out_data is a single register, not a memory, so it is reset along
  // with the rest of the state to give a defined value after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      rr_ptr    <= SELW'(N - 1);  // first round-robin grant goes to channel 0
    end else if (load_en) begin
      if (grant_valid) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        out_data  <= grant_data;
        out_src   <= grant;
        out_valid <= 1'b1;
        rr_ptr    <= grant;
      end else begin
        out_valid <= 1'b0;  // data and tag keep their last values
      end
    end
  end

endmodule
